// File: rtl/serial_vector_assembler_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg : definitions shared by the serial vector assembler and the
//           downstream field-splitter stage.
//   VEC_W        default vector width (WIDTH parameter default)
//   VEC_W_MAX    widest legal vector; the parity helper takes this width
//   vec_t        default-width vector type, reused by the splitter
//   even_parity  XOR-reduce of a (zero-extended) vector
// -----------------------------------------------------------------------------
package vec_pkg;

  localparam int VEC_W     = 8;
  localparam int VEC_W_MAX = 32;

  typedef logic [VEC_W-1:0] vec_t;

  // Zero-extension by the caller does not change the XOR-reduce result.
  function automatic logic even_parity(input logic [VEC_W_MAX-1:0] vec);
    even_parity = ^vec;
  endfunction

endpackage

// File: rtl/serial_vector_assembler_if.sv
// -----------------------------------------------------------------------------
// serial_vector_assembler_if : serial input handshake plus assembled-vector
// output handshake of the serial vector assembler.
//   ser_in/ser_valid/ser_ready      serial bit beat (valid/ready)
//   out_vec/out_valid/out_ready     assembled vector (valid/ready)
//   busy                            partial vector in progress
//   parity_err                      only with PARITY_CHECK_EN defined
// Modports: master = assembler side, slave = environment side.
// -----------------------------------------------------------------------------
interface serial_vector_assembler_if
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_W
);

  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [WIDTH-1:0] out_vec;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef PARITY_CHECK_EN
  logic             parity_err;

  modport master (
    input  ser_in, ser_valid, out_ready,
    output ser_ready, out_vec, out_valid, busy, parity_err
  );

  modport slave (
    output ser_in, ser_valid, out_ready,
    input  ser_ready, out_vec, out_valid, busy, parity_err
  );
`else
  modport master (
    input  ser_in, ser_valid, out_ready,
    output ser_ready, out_vec, out_valid, busy
  );

  modport slave (
    output ser_in, ser_valid, out_ready,
    input  ser_ready, out_vec, out_valid, busy
  );
`endif

endinterface

// File: rtl/serial_vector_assembler.sv
// -----------------------------------------------------------------------------
// serial_vector_assembler : gathers one serial bit per accepted beat into
// WIDTH-bit vectors and presents each completed vector on a one-entry
// valid/ready output register (feeds the field splitter directly).
//
// Parameters
//   WIDTH      bits per vector, 2..32
//   MSB_FIRST  1: first received bit lands in out_vec[WIDTH-1]
//              0: first received bit lands in out_vec[0]
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   serial_vector_assembler_if.master (ser_*, out_*, busy[, parity_err])
// Optional feature macro: PARITY_CHECK_EN
//   Frames become WIDTH data bits plus one trailing even-parity bit. A frame
//   with bad parity is dropped and parity_err pulses for one cycle.
// -----------------------------------------------------------------------------
module serial_vector_assembler
  import vec_pkg::*;
#(
  parameter int WIDTH     = VEC_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                        clk,
  input logic                        rst,
  serial_vector_assembler_if.master  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  // The parity bit is the completion beat.
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] out_vec_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             last_beat_s;
  logic             ser_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             load_s;
  logic [WIDTH-1:0] load_word_s;
  logic             par_bad_s;

`ifdef PARITY_CHECK_EN
  logic             parity_err_r;
`endif

  // Stall only the completion beat, and only while the output holds an
  // unconsumed vector that is not being drained this cycle.
  assign last_beat_s = (count_r == LAST_CNT);
  assign ser_ready_s = !(last_beat_s && out_valid_r && !bus.out_ready);
  assign accept_s    = bus.ser_valid && ser_ready_s;

  // Shift direction, next shift/count and output-register load decision.
  always_comb begin
    shifted_s   = shift_r;
    shift_nxt_s = shift_r;
    count_nxt_s = count_r;
    load_s      = 1'b0;
    load_word_s = shift_r;
    par_bad_s   = 1'b0;

    if (MSB_FIRST) begin
      shifted_s = {shift_r[WIDTH-2:0], bus.ser_in};
    end else begin
      shifted_s = {bus.ser_in, shift_r[WIDTH-1:1]};
    end

    if (accept_s) begin
      if (last_beat_s) begin
        count_nxt_s = {CNT_W{1'b0}};
      end else begin
        count_nxt_s = count_r + ONE_CNT;
      end
    end else begin
      count_nxt_s = count_r;
    end

`ifdef PARITY_CHECK_EN
    // Parity beat does not enter the shift register; data is already complete.
    if (accept_s && !last_beat_s) begin
      shift_nxt_s = shifted_s;
    end else begin
      shift_nxt_s = shift_r;
    end
    load_word_s = shift_r;
    if (accept_s && last_beat_s) begin
      par_bad_s = even_parity(VEC_W_MAX'(shift_r)) ^ bus.ser_in;
      load_s    = !par_bad_s;
    end else begin
      par_bad_s = 1'b0;
      load_s    = 1'b0;
    end
`else
    // The completed word includes the bit accepted on the completion beat.
    if (accept_s) begin
      shift_nxt_s = shifted_s;
    end else begin
      shift_nxt_s = shift_r;
    end
    load_word_s = shifted_s;
    load_s      = accept_s && last_beat_s;
    par_bad_s   = 1'b0;
`endif
  end

  // Shift register, bit count and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      shift_r <= shift_nxt_s;
      count_r <= count_nxt_s;
      busy_r  <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  // One-entry output register; a load while draining keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vec_r   <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_vec_r   <= load_word_s;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef PARITY_CHECK_EN
  // Single-cycle error pulse following a bad parity beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= par_bad_s;
    end
  end

  assign bus.parity_err = parity_err_r;
`endif

  assign bus.ser_ready = ser_ready_s;
  assign bus.out_vec   = out_vec_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_serial_vector_assembler.sv
// -----------------------------------------------------------------------------
// tb_serial_vector_assembler : drives one bit stream into an MSB-first and an
// LSB-first assembler side by side and compares both against a frame-level
// reference model (bit queue -> word by position arithmetic, one-entry output).
// -----------------------------------------------------------------------------
module tb_serial_vector_assembler;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_vector_assembler_if #(.WIDTH(W)) sif_m ();
  serial_vector_assembler_if #(.WIDTH(W)) sif_l ();

  serial_vector_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (sif_m)
  );

  serial_vector_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (sif_l)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit         bits_q[$];
  logic [W-1:0] m_word_m = '0;
  logic [W-1:0] m_word_l = '0;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;
  bit         m_known = 1'b0;
  bit         last_acc = 1'b0;
  logic       last_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Word value of the first W received bits, by bit position.
  function automatic logic [W-1:0] assemble(input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w = w | (W'(bits_q[i]) << (W - 1 - i));
      else           w = w | (W'(bits_q[i]) << i);
    end
    return w;
  endfunction

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic drive(input logic v, input logic b, input logic r, input logic rs);
    bit exp_ready;
    bit acc;
    bit ok;
    bit loaded;
    rst = rs;
    sif_m.ser_valid = v; sif_m.ser_in = b; sif_m.out_ready = r;
    sif_l.ser_valid = v; sif_l.ser_in = b; sif_l.out_ready = r;
    #1;
    exp_ready  = !(bits_q.size() == FRAME - 1 && m_valid && !r);
    last_ready = sif_m.ser_ready;
    if (m_known) begin
      check("ser_ready_msb", {31'd0, sif_m.ser_ready}, {31'd0, exp_ready});
      check("ser_ready_lsb", {31'd0, sif_l.ser_ready}, {31'd0, exp_ready});
    end
    acc = v && exp_ready && !rs;
    @(posedge clk);
    if (rs) begin
      bits_q.delete();
      m_word_m = '0; m_word_l = '0; m_valid = 1'b0; m_err = 1'b0;
      m_known  = 1'b1;
    end else begin
      loaded = 1'b0;
      m_err  = 1'b0;
      if (acc) begin
        bits_q.push_back(b);
        if (bits_q.size() == FRAME) begin
          ok = 1'b1;
`ifdef PARITY_CHECK_EN
          ok = 1'b1;
          foreach (bits_q[i]) ok = ok ^ bits_q[i];
`endif
          if (ok) begin
            m_word_m = assemble(1'b1);
            m_word_l = assemble(1'b0);
            loaded   = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          bits_q.delete();
        end
      end
      if (loaded)     m_valid = 1'b1;
      else if (r)     m_valid = 1'b0;
    end
    last_acc = acc;
    @(negedge clk);
    check("out_valid_msb", {31'd0, sif_m.out_valid}, {31'd0, m_valid});
    check("out_valid_lsb", {31'd0, sif_l.out_valid}, {31'd0, m_valid});
    check("out_vec_msb", 32'(sif_m.out_vec), 32'(m_word_m));
    check("out_vec_lsb", 32'(sif_l.out_vec), 32'(m_word_l));
    check("busy_msb", {31'd0, sif_m.busy}, {31'd0, bits_q.size() != 0});
    check("busy_lsb", {31'd0, sif_l.busy}, {31'd0, bits_q.size() != 0});
`ifdef PARITY_CHECK_EN
    check("parity_err_msb", {31'd0, sif_m.parity_err}, {31'd0, m_err});
    check("parity_err_lsb", {31'd0, sif_l.parity_err}, {31'd0, m_err});
`endif
  endtask

  // Frame bits in transmission order: word MSB down to LSB, then parity.
  task automatic frame_bits(input logic [W-1:0] word, output bit q[$]);
    q.delete();
    for (int i = W - 1; i >= 0; i--) q.push_back(word[i]);
`ifdef PARITY_CHECK_EN
    q.push_back(^word);
`endif
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit gaps);
    bit q[$];
    frame_bits(word, q);
    foreach (q[i]) begin
      drive(1'b1, q[i], 1'b1, 1'b0);
      if (gaps) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
  endtask

  initial begin
    bit stream[$];
    bit q2[$];
    int idx;
    int cyc;
    bit saw_stall;

    sif_m.ser_valid = 1'b0; sif_m.ser_in = 1'b0; sif_m.out_ready = 1'b0;
    sif_l.ser_valid = 1'b0; sif_l.ser_in = 1'b0; sif_l.out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_valid", {31'd0, sif_m.out_valid}, 32'd0);
    check("rst_vec", 32'(sif_m.out_vec), 32'd0);
    check("rst_busy", {31'd0, sif_m.busy}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_ready", {31'd0, last_ready}, 32'd1);

    // 0xD6 bit order on consecutive cycles, downstream always ready
    send_frame(8'hD6, 1'b0);
    check("d6_msb_first", 32'(sif_m.out_vec), 32'h0000_00D6);
    check("d6_lsb_first", 32'(sif_l.out_vec), 32'h0000_006B);
    check("d6_valid", {31'd0, sif_m.out_valid}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("d6_drained", {31'd0, sif_m.out_valid}, 32'd0);

    // Back-to-back 0xD6, 0x3C with out_ready low for the first 19 cycles
    frame_bits(8'hD6, stream);
    frame_bits(8'h3C, q2);
    foreach (q2[i]) stream.push_back(q2[i]);
    idx = 0; cyc = 0; saw_stall = 1'b0;
    while (idx < stream.size() && cyc < 60) begin
      drive(1'b1, stream[idx], 1'(cyc >= 19), 1'b0);
      if (!last_ready) saw_stall = 1'b1;
      if (last_acc) idx++;
      cyc++;
    end
    check("b2b_done_in_budget", 32'(idx), 32'(stream.size()));
    check("b2b_stall_seen", {31'd0, saw_stall}, 32'd1);
    check("b2b_second_word", 32'(sif_m.out_vec), 32'h0000_003C);
    check("b2b_valid", {31'd0, sif_m.out_valid}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Partial frame discarded by reset, then a clean 0xA5 frame
    for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("mid_rst_busy", {31'd0, sif_m.busy}, 32'd0);
    check("mid_rst_valid", {31'd0, sif_m.out_valid}, 32'd0);
    send_frame(8'hA5, 1'b0);
    check("a5_after_rst", 32'(sif_m.out_vec), 32'h0000_00A5);

    // ser_valid toggling every cycle
    send_frame(8'h81, 1'b1);
    check("gapped_81", 32'(sif_m.out_vec), 32'h0000_0081);
    check("gapped_81_lsb", 32'(sif_l.out_vec), 32'h0000_0081);

`ifdef PARITY_CHECK_EN
    // Good parity then bad parity on 0xD6
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b1, W'(8'hD6) >> i & 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("par_ok_valid", {31'd0, sif_m.out_valid}, 32'd1);
    check("par_ok_err", {31'd0, sif_m.parity_err}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b1, W'(8'hD6) >> i & 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("par_bad_valid", {31'd0, sif_m.out_valid}, 32'd0);
    check("par_bad_err", {31'd0, sif_m.parity_err}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("par_err_one_cycle", {31'd0, sif_m.parity_err}, 32'd0);
`endif

    // Randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
